// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder family.
// Latency: n/a (package only).
// Backpressure: n/a.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int chunk_w(input int width, input int stages);
        return (stages < 1) ? width : width / stages;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// C-bit ripple chunk built from full_adder cells; exposes the carry into its top bit.
// Latency: combinational.
// Backpressure: none.
module adder_stage
    import adder_pkg::*;
#(
    parameter int C = 4
) (
    input  logic [C-1:0] a,
    input  logic [C-1:0] b,
    input  logic         ci,
    output logic [C-1:0] sum,
    output logic         co,
    output logic         c_msb_in
);

    logic [C:0] carry;

    assign carry[0] = ci;

    for (genvar i = 0; i < C; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .ci  (carry[i]),
            .sum (sum[i]),
            .co  (carry[i+1])
        );
    end

    assign co       = carry[C];
    assign c_msb_in = carry[C-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder, the leaf cell of every ripple chunk.
// Latency: combinational.
// Backpressure: none.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum,
    output logic co
);

    assign sum = a ^ b ^ ci;
    assign co  = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract, one WIDTH/STAGES-bit chunk per stage with carry, skew and deskew registers.
// Latency: STAGES cycles with en high; each en=0 cycle adds one.
// Backpressure: single global advance enable, s_ready = m_ready | ~m_valid; bubbles are not collapsed.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int C = chunk_w(WIDTH, STAGES);

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    op_e  op;
    logic en;

    // Stage k inputs: operands carried so far, and the carry from stage k-1.
    logic [WIDTH-1:0] st_a    [STAGES];
    logic [WIDTH-1:0] st_b    [STAGES];
    logic             st_ci   [STAGES];
    logic [C-1:0]     st_sum  [STAGES];
    logic             st_co   [STAGES];
    logic             st_cm   [STAGES];
    logic [WIDTH-1:0] st_nsum [STAGES];

    logic [STAGES-1:0] vld_q;
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic              carry_q [STAGES];
    logic              ovf_q;

    assign op      = op_e'(sub);
    assign en      = m_ready | ~m_valid;
    assign s_ready = en;

    // b is inverted once at the input, so later stages never need to know the op.
    always_comb begin
        st_a[0]  = a;
        st_b[0]  = (op == OP_SUB) ? ~b : b;
        st_ci[0] = (op == OP_SUB) ? 1'b1 : ci;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k]  = a_q[k-1];
            st_b[k]  = b_q[k-1];
            st_ci[k] = carry_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_stage #(
            .C (C)
        ) u_stage (
            .a        (st_a[k][k*C +: C]),
            .b        (st_b[k][k*C +: C]),
            .ci       (st_ci[k]),
            .sum      (st_sum[k]),
            .co       (st_co[k]),
            .c_msb_in (st_cm[k])
        );
    end

    // Deskew: each stage merges its fresh chunk into the partial sum from the stage before.
    always_comb begin
        st_nsum[0]        = '0;
        st_nsum[0][C-1:0] = st_sum[0];
        for (int k = 1; k < STAGES; k++) begin
            st_nsum[k]           = sum_q[k-1];
            st_nsum[k][k*C +: C] = st_sum[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
            end
        end else if (en) begin
            vld_q[0] <= s_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]     <= st_a[k];
                b_q[k]     <= st_b[k];
                sum_q[k]   <= st_nsum[k];
                carry_q[k] <= st_co[k];
            end
            ovf_q <= st_co[STAGES-1] ^ st_cm[STAGES-1];
        end
    end

    assign m_valid = vld_q[STAGES-1];
    assign sum     = sum_q[STAGES-1];
    assign co      = carry_q[STAGES-1];
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder at WIDTH=8, STAGES=2: directed vectors, stall and reset sequences, random scoreboard.
// Latency: expects results 2 cycles after acceptance.
// Backpressure: drives m_ready patterns and holds inputs until accepted.
module tb_pipelined_adder;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipelined_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .a       (a),
        .b       (b),
        .ci      (ci),
        .sub     (sub),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .sum     (sum),
        .co      (co),
        .ovf     (ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sub;
        logic [7:0] sum;
        logic       co;
        logic       ovf;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: {ovf, co, sum}
    function automatic logic [9:0] model(input logic [7:0] xa, input logic [7:0] xb,
                                         input logic xci, input logic xsub);
        logic [8:0] r;
        int         sr;
        if (xsub) begin
            r  = {1'b0, xa} + {1'b0, ~xb} + 9'd1;
            sr = int'($signed(xa)) - int'($signed(xb));
        end else begin
            r  = {1'b0, xa} + {1'b0, xb} + {8'd0, xci};
            sr = int'($signed(xa)) + int'($signed(xb)) + int'({31'd0, xci});
        end
        return {(sr > 127 || sr < -128), r};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] got [$];
        logic [9:0] exp_q [$];
        logic [9:0] e;
        int         issued;
        int         sent;
        int         cyc;
        logic       pending;

        vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[2]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4]  = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[5]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[7]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[8]  = '{8'h10, 8'h10, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[11] = '{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[12] = '{8'hF0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{8'h12, 8'h34, 1'b0, 1'b1, 8'hDE, 1'b0, 1'b0};

        // Reset held two cycles while upstream offers a transaction.
        rst = 1'b1; s_valid = 1'b1; a = 8'h55; b = 8'h22; ci = 1'b1; sub = 1'b0; m_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_m_valid", m_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_co", co, 0);
        check("rst_ovf", ovf, 0);
        check("rst_s_ready", s_ready, 1);
        rst = 1'b0; s_valid = 1'b0;
        repeat (4) begin
            @(negedge clk); #1;
            check("rst_no_output", m_valid, 0);
        end

        // Directed vectors, one at a time, checking exact 2-cycle latency.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; ci = vecs[i].ci; sub = vecs[i].sub;
            s_valid = 1'b1; m_ready = 1'b1;
            #1 check($sformatf("vec%0d_s_ready", i), s_ready, 1);
            @(negedge clk);
            s_valid = 1'b0;
            #1 check($sformatf("vec%0d_early", i), m_valid, 0);
            @(negedge clk); #1;
            check($sformatf("vec%0d_m_valid", i), m_valid, 1);
            check($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
            check($sformatf("vec%0d_co", i), co, vecs[i].co);
            check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
        end
        @(negedge clk);

        // Backpressure: 4 back-to-back adds, m_ready low for cycles 2..4.
        issued = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            m_ready = !(c >= 2 && c <= 4);
            if (issued < 4) begin
                s_valid = 1'b1;
                a = 8'(issued + 1); b = 8'(issued + 1); ci = 1'b0; sub = 1'b0;
            end else begin
                s_valid = 1'b0;
            end
            #1;
            check($sformatf("bp_s_ready_c%0d", c), s_ready, (c >= 2 && c <= 4) ? 0 : 1);
            if (c >= 2 && c <= 4) begin
                check($sformatf("bp_stall_valid_c%0d", c), m_valid, 1);
                check($sformatf("bp_stall_sum_c%0d", c), sum, 8'h02);
            end
            if (m_valid && m_ready) got.push_back(sum);
            if (s_valid && s_ready) issued++;
        end
        check("bp_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check($sformatf("bp_result%0d", i), got[i], 8'(2 * (i + 1)));

        // Reset with two transactions in flight.
        @(negedge clk);
        s_valid = 1'b1; a = 8'd10; b = 8'd20; ci = 1'b0; sub = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        a = 8'd30;
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0; rst = 1'b1;
        #1 check("mid_inflight", m_valid, 1);
        @(negedge clk);
        rst = 1'b0; m_ready = 1'b1;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_s_ready", s_ready, 1);
        repeat (5) begin
            @(negedge clk); #1;
            check("mid_no_stale", m_valid, 0);
        end

        // Random stream with scoreboard.
        sent = 0; cyc = 0; pending = 1'b0; s_valid = 1'b0;
        while ((sent < 10000 || exp_q.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!pending) begin
                if (sent < 10000 && $urandom_range(3) != 0) begin
                    s_valid = 1'b1;
                    a = 8'($urandom); b = 8'($urandom);
                    ci = 1'($urandom); sub = 1'($urandom);
                end else begin
                    s_valid = 1'b0;
                end
            end
            m_ready = (sent >= 10000) ? 1'b1 : ($urandom_range(3) != 0);
            #1;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rand_result", {ovf, co, sum}, e);
                end
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(model(a, b, ci, sub));
                sent++;
                pending = 1'b0;
            end else begin
                pending = s_valid;
            end
        end
        check("rand_sent", sent, 10000);
        check("rand_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the single-bit `full_adder`. Adds or subtracts two `WIDTH`-bit operands over `STAGES` register stages, each resolving one `WIDTH/STAGES`-bit chunk and passing its carry forward. A valid/ready handshake lets it sit between streaming datapath blocks. Throughput is one operation per cycle, with backpressure.

## Interface

Parameters:
- `WIDTH`, 16: operand and result width.
- `STAGES`, 4: pipeline depth. `WIDTH % STAGES == 0` and `STAGES >= 1` are required; any other value is an elaboration `$error`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `s_valid`, in, 1: input transaction present.
- `s_ready`, out, 1: block can accept an input this cycle.
- `a`, in, `WIDTH`: operand A.
- `b`, in, `WIDTH`: operand B.
- `ci`, in, 1: carry in. Ignored when `sub=1`.
- `sub`, in, 1: 0 computes a+b+ci; 1 computes a−b, implemented as a+~b+1.
- `m_valid`, out, 1: result present.
- `m_ready`, in, 1: downstream accepts the result.
- `sum`, out, `WIDTH`: result.
- `co`, out, 1: carry out of the MSB. For subtract, 1 means no borrow.
- `ovf`, out, 1: signed overflow, equal to carry into MSB XOR carry out of MSB.

## Operation

- Chunk width is `C = WIDTH/STAGES`. Stage k adds bits `[k*C +: C]` of the operands, using the carry registered by stage k−1. Stage 0 uses `ci`, or 1 when `sub=1`.
- Operand bits for stages not yet computed travel with the transaction in skew registers.
- Sum chunks already computed travel in deskew registers, so all of `sum`, `co` and `ovf` present together.
- `b` is inverted at the input when `sub=1`.
- `ovf` is derived in the last stage from the MSB carry-in and carry-out.
- Pipeline control uses a single advance enable: `en = m_ready | ~m_valid`.
  - All stage registers, including per-stage valid bits, load only when `en=1`.
  - `s_ready = en`, which is combinational.
  - Bubbles are not collapsed.
- Input transfer happens when `s_valid & s_ready`. Output transfer happens when `m_valid & m_ready`.
- When `s_valid=0` and `en=1`, a bubble (valid bit 0) enters stage 0.
- Reset:
  - All valid bits, data, carry and skew registers clear to 0.
  - Outputs after reset: `m_valid=0`, `sum=0`, `co=0`, `ovf=0`, `s_ready=1`.
  - Reset mid-stream discards every in-flight transaction; nothing issued before reset ever appears at the output.
  - Reset has priority over `en`.
- While `m_valid=1` and `m_ready=0`, `sum`, `co` and `ovf` hold stable.
- Results leave in strict input order, with no loss and no duplication.
- Operands are unsigned for `sum` and `co`, and two's-complement for `ovf`.

## Timing

- Latency: an input accepted in cycle t produces `m_valid=1` with its result in cycle t+`STAGES`, provided `en` stays high throughout.
- Each cycle with `en=0` adds one cycle of latency to every in-flight transaction.
- Full throughput: with `m_ready` held high, one result per cycle and `s_ready` constantly 1.
- Stall: `m_ready=0` while `m_valid=1` drops `s_ready` in the same cycle. Upstream must hold `a`, `b`, `ci` and `sub` stable until it sees `s_ready`.
- Critical path is one C-bit ripple, the carry register setup, and the `en` fan-out.
- `STAGES=1`: a registered full-width adder with latency 1.

## Structure

- `adder_pkg` holds:
  - the `op_e` typedef: `OP_ADD=1'b0`, `OP_SUB=1'b1`;
  - the function `chunk_w(WIDTH, STAGES)`.
- Sub-module `adder_stage #(C)`: a combinational C-bit ripple chain of `full_adder` instances.
  - Ports: `a`, `b`, `ci`, `sum`, `co`, and `c_msb_in`, the carry into its top bit, used for `ovf`.
- `pipelined_adder` instantiates `STAGES` copies of `adder_stage` in a generate loop and owns all registers, the valid chain and `en`.

## Test plan

Scenarios use `WIDTH=8`, `STAGES=2`, so latency is 2.

- Reset: hold `rst=1` for 2 cycles with `s_valid=1` → `m_valid=0`, `sum=0`, `co=0`, `ovf=0`, `s_ready=1`; no output appears afterwards.
- Carry across chunk boundary: a=8'hFF, b=8'h01, ci=0, sub=0 → 2 cycles later `sum=8'h00`, `co=1`, `ovf=0`. Then a=8'h0F, b=8'h00, ci=1 → `sum=8'h10`, `co=0`.
- Signed overflow: a=8'h7F, b=8'h01, sub=0 → `sum=8'h80`, `co=0`, `ovf=1`. Then a=8'h80, b=8'h01, sub=1 → `sum=8'h7F`, `co=1`, `ovf=1`.
- Subtract with borrow: a=8'h05, b=8'h07, sub=1, ci=1 (ignored) → `sum=8'hFE`, `co=0`, `ovf=0`.
- Backpressure: issue 4 back-to-back adds (1+1, 2+2, 3+3, 4+4), dropping `m_ready` for 3 cycles after the first result.
  - Required: results 2, 4, 6, 8 in order, exactly once each.
  - `sum` stable while stalled; `s_ready=0` exactly in the stall cycles.
- Reset mid-stream plus randomized run:
  - Assert `rst` for 1 cycle with 2 transactions in flight → no stale output.
  - Then 10k random a/b/ci/sub with random `m_ready`. A scoreboard checks `{co,sum}` against a+b+ci (or a+~b+1), `ovf` against the signed reference, and ordering.
